// File: rtl/cordic_sum_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cordic_sum_sequencer_pkg
// Purpose  : Shared types and constants for the CORDIC sum sequencer: FSM
//            state encoding, default wait timeout and IEEE-754 constants.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_sum_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_CORDIC = 3'd2,
    S_ADD    = 3'd3,
    S_FINISH = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  localparam int          DEFAULT_TIMEOUT = 1023;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage : cordic_sum_sequencer_pkg
`default_nettype wire

// File: rtl/seq_watchdog.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_watchdog
// Purpose  : Wait-cycle counter for the sequencer. Counts every cycle while
//            clear is low and flags expiry once TIMEOUT cycles have been
//            spent waiting. Saturates so it can never wrap back to zero.
// Ports    : clk     - rising-edge clock
//            rst_n   - synchronous active-low reset
//            clear   - hold/restart the count at zero
//            expired - high on the TIMEOUT-th consecutive uncleared cycle
// Revision : 1.0 - initial release
// ============================================================================
module seq_watchdog
  import cordic_sum_sequencer_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);

  localparam int              CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The count starts at 0 in the first waiting cycle, so the TIMEOUT-th
  // waiting cycle sees TIMEOUT-1.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != LIMIT) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule : seq_watchdog
`default_nettype wire

// File: rtl/cordic_sum_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cordic_sum_sequencer
// Purpose  : Sequences a job of len operands through an external CORDIC unit
//            and an external FP adder, accumulating acc = init_sum + sum f(x).
//            No arithmetic is done here; the sum comes only from add_result.
// Ports    : clk, rst_n            - clock, synchronous active-low reset
//            start, len, init_sum  - job request (sampled in IDLE only)
//            in_valid/in_ready/in_data            - operand stream
//            cordic_start/cordic_data/cordic_done/cordic_result - CORDIC
//            add_enable/add_dataa/add_datab/add_done/add_result  - FP adder
//            result, done, busy, error            - job status
// Revision : 1.0 - initial release
// ============================================================================
module cordic_sum_sequencer
  import cordic_sum_sequencer_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      init_sum,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             cordic_start,
  output logic [31:0]      cordic_data,
  input  logic             cordic_done,
  input  logic [31:0]      cordic_result,
  output logic             add_enable,
  output logic [31:0]      add_dataa,
  output logic [31:0]      add_datab,
  input  logic             add_done,
  input  logic [31:0]      add_result,
  output logic [31:0]      result,
  output logic             done,
  output logic             busy,
  output logic             error
);

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      result_q, result_d;
  logic [LEN_W-1:0] remcnt_q, remcnt_d;
  logic [31:0]      cordic_data_q, cordic_data_d;
  logic [31:0]      add_dataa_q, add_dataa_d;
  logic [31:0]      add_datab_q, add_datab_d;
  logic             cordic_start_q, cordic_start_d;
  logic             add_enable_q, add_enable_d;
  logic             done_q, done_d;

  logic             wd_clear;
  logic             wd_expired;

  // Next-state and datapath updates. Pulses default low so each is a
  // single registered cycle taken only on the transition that raises it.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    result_d       = result_q;
    remcnt_d       = remcnt_q;
    cordic_data_d  = cordic_data_q;
    add_dataa_d    = add_dataa_q;
    add_datab_d    = add_datab_q;
    cordic_start_d = 1'b0;
    add_enable_d   = 1'b0;
    done_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = init_sum;
          remcnt_d = len;
          state_d  = (len == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        if (in_valid) begin
          cordic_data_d  = in_data;
          cordic_start_d = 1'b1;
          state_d        = S_CORDIC;
        end
      end
      S_CORDIC: begin
        // A done arriving on the expiry cycle still counts.
        if (cordic_done) begin
          add_dataa_d  = cordic_result;
          add_datab_d  = acc_q;
          add_enable_d = 1'b1;
          state_d      = S_ADD;
        end else if (wd_expired) begin
          state_d = S_FAULT;
        end
      end
      S_ADD: begin
        if (add_done) begin
          acc_d    = add_result;
          remcnt_d = remcnt_q - LEN_W'(1);
          state_d  = (remcnt_q == LEN_W'(1)) ? S_FINISH : S_FETCH;
        end else if (wd_expired) begin
          state_d = S_FAULT;
        end
      end
      S_FINISH: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      acc_q          <= FP_ZERO;
      result_q       <= FP_ZERO;
      remcnt_q       <= '0;
      cordic_data_q  <= FP_ZERO;
      add_dataa_q    <= FP_ZERO;
      add_datab_q    <= FP_ZERO;
      cordic_start_q <= 1'b0;
      add_enable_q   <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      remcnt_q       <= remcnt_d;
      cordic_data_q  <= cordic_data_d;
      add_dataa_q    <= add_dataa_d;
      add_datab_q    <= add_datab_d;
      cordic_start_q <= cordic_start_d;
      add_enable_q   <= add_enable_d;
      done_q         <= done_d;
    end
  end

  // Restart the wait count on every state change so CORDIC->ADD starts
  // from zero too, and keep it parked outside the two waiting states.
  assign wd_clear = ((state_q != S_CORDIC) && (state_q != S_ADD)) ||
                    (state_d != state_q);

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .expired (wd_expired)
  );

  assign in_ready     = (state_q == S_FETCH);
  assign busy         = (state_q != S_IDLE);
  assign error        = (state_q == S_FAULT);
  assign result       = result_q;
  assign done         = done_q;
  assign cordic_start = cordic_start_q;
  assign cordic_data  = cordic_data_q;
  assign add_enable   = add_enable_q;
  assign add_dataa    = add_dataa_q;
  assign add_datab    = add_datab_q;

endmodule : cordic_sum_sequencer
`default_nettype wire

// File: tb/tb_cordic_sum_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cordic_sum_sequencer
// Purpose  : Directed self-checking bench for cordic_sum_sequencer with a
//            20-cycle CORDIC model (f(x) = 2x) and a 6-cycle FP adder model.
//            A second instance with TIMEOUT=15 and a silent CORDIC covers
//            the fault path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_sum_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  // Main instance
  logic        start, in_valid, in_ready;
  logic [7:0]  len;
  logic [31:0] init_sum, in_data;
  logic        cordic_start, cordic_done, add_enable, add_done;
  logic [31:0] cordic_data, cordic_result, add_dataa, add_datab, add_result;
  logic [31:0] result;
  logic        done, busy, error;

  // Timeout instance
  logic        start_t, in_valid_t, in_ready_t;
  logic [7:0]  len_t;
  logic [31:0] init_t, in_data_t;
  logic        cordic_start_t, add_enable_t;
  logic [31:0] cordic_data_t, add_dataa_t, add_datab_t, result_t;
  logic        done_t, busy_t, error_t;

  cordic_sum_sequencer #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .init_sum(init_sum),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cordic_start(cordic_start), .cordic_data(cordic_data),
    .cordic_done(cordic_done), .cordic_result(cordic_result),
    .add_enable(add_enable), .add_dataa(add_dataa), .add_datab(add_datab),
    .add_done(add_done), .add_result(add_result),
    .result(result), .done(done), .busy(busy), .error(error)
  );

  cordic_sum_sequencer #(.LEN_W(8), .TIMEOUT(15)) dut_to (
    .clk(clk), .rst_n(rst_n), .start(start_t), .len(len_t), .init_sum(init_t),
    .in_valid(in_valid_t), .in_ready(in_ready_t), .in_data(in_data_t),
    .cordic_start(cordic_start_t), .cordic_data(cordic_data_t),
    .cordic_done(1'b0), .cordic_result(32'h0),
    .add_enable(add_enable_t), .add_dataa(add_dataa_t), .add_datab(add_datab_t),
    .add_done(1'b0), .add_result(32'h0),
    .result(result_t), .done(done_t), .busy(busy_t), .error(error_t)
  );

  // ---------------------------------------------------------------- models
  function automatic real sp2real(input logic [31:0] s);
    logic [63:0] d;
    logic [10:0] e;
    if (s[30:0] == 31'd0) return 0.0;
    e = {3'b000, s[30:23]} + 11'd896;
    d = {s[31], e, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // CORDIC stand-in: doubles a normal single by bumping its exponent.
  function automatic logic [31:0] cordic_f(input logic [31:0] x);
    return x + 32'h0080_0000;
  endfunction

  int          cm_cnt = 0, am_cnt = 0;
  logic [31:0] cm_arg = 32'h0, cm_res = 32'h0, am_a = 32'h0, am_b = 32'h0;
  logic        cm_done = 1'b0, spur_cd = 1'b0;

  always @(posedge clk) begin
    cm_done <= 1'b0;
    if (cordic_start) begin
      cm_cnt <= 20;
      cm_arg <= cordic_data;
    end else if (cm_cnt != 0) begin
      cm_cnt <= cm_cnt - 1;
      if (cm_cnt == 1) begin
        cm_done <= 1'b1;
        cm_res  <= cordic_f(cm_arg);
      end
    end
  end

  always @(posedge clk) begin
    add_done <= 1'b0;
    if (add_enable) begin
      am_cnt <= 6;
      am_a   <= add_dataa;
      am_b   <= add_datab;
    end else if (am_cnt != 0) begin
      am_cnt <= am_cnt - 1;
      if (am_cnt == 1) begin
        add_done   <= 1'b1;
        add_result <= real2sp(sp2real(am_a) + sp2real(am_b));
      end
    end
  end

  assign cordic_done   = cm_done | spur_cd;
  assign cordic_result = spur_cd ? 32'h7F80_0000 : cm_res;

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver
  logic [31:0] ops [4];
  int n_ops = 0, op_idx = 0, mon_cycles = 0, done_at = -1, restart_at = -1;
  int mon_cs = 0, mon_ae = 0, mon_both = 0, mon_done = 0;
  bit pending = 1'b0, spur_en = 1'b0;

  task automatic clear_mon();
    mon_cs = 0; mon_ae = 0; mon_both = 0; mon_done = 0;
    mon_cycles = 0; done_at = -1; op_idx = 0; pending = 1'b0;
  endtask

  // One cycle: observe outputs at the negedge, then drive the next inputs.
  task automatic step();
    @(negedge clk);
    mon_cycles++;
    if (pending) op_idx++;
    if (cordic_start) mon_cs++;
    if (add_enable) mon_ae++;
    if (cordic_start && add_enable) mon_both++;
    if (done) begin
      mon_done++;
      if (done_at < 0) done_at = mon_cycles;
    end
    start    = (mon_cycles == restart_at);
    spur_cd  = spur_en && add_enable;
    in_valid = (op_idx < n_ops) && ((mon_cycles % 3) != 1);
    in_data  = in_valid ? ops[op_idx] : 32'hDEAD_BEEF;
    pending  = in_valid && in_ready;
  endtask

  task automatic launch(input logic [7:0] l, input logic [31:0] init);
    clear_mon();
    @(negedge clk);
    start    = 1'b1;
    len      = l;
    init_sum = init;
    in_valid = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    while (done_at < 0 && mon_cycles < budget) step();
    if (done_at < 0) check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
    repeat (3) step();
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    int n;
    int dt;
    rst_n = 1'b0; start = 1'b0; len = '0; init_sum = '0; in_valid = 1'b0;
    in_data = '0; start_t = 1'b0; len_t = '0; init_t = '0; in_valid_t = 1'b0;
    in_data_t = '0;
    repeat (3) @(negedge clk);

    check_eq("rst_result", result, 32'h0);
    check_eq("rst_flags", {26'd0, done, busy, error, in_ready, cordic_start,
             add_enable}, 32'h0);
    check_eq("rst_cdata", cordic_data, 32'h0);
    check_eq("rst_adda", add_dataa, 32'h0);
    check_eq("rst_addb", add_datab, 32'h0);
    rst_n = 1'b1;

    // len=0: straight to FINISH, init_sum passes through untouched.
    n_ops = 0;
    launch(8'd0, 32'h4049_0FDB);
    run_until_done("len0", 50);
    check_eq("len0_result", result, 32'h4049_0FDB);
    check_eq("len0_latency", 32'(done_at), 32'd2);
    check_eq("len0_cs", 32'(mon_cs), 32'd0);
    check_eq("len0_done_cnt", 32'(mon_done), 32'd1);
    check_eq("len0_busy_after", 32'(busy), 32'd0);

    // len=3, gapped valid: 2+4+6 = 12.0
    ops[0] = 32'h3F80_0000; ops[1] = 32'h4000_0000; ops[2] = 32'h4040_0000;
    n_ops = 3;
    launch(8'd3, 32'h0);
    run_until_done("len3", 500);
    check_eq("len3_result", result, 32'h4140_0000);
    check_eq("len3_cs", 32'(mon_cs), 32'd3);
    check_eq("len3_ae", 32'(mon_ae), 32'd3);
    check_eq("len3_overlap", 32'(mon_both), 32'd0);
    check_eq("len3_consumed", 32'(op_idx), 32'd3);
    check_eq("len3_done_cnt", 32'(mon_done), 32'd1);

    // Mid-job start and spurious cordic_done in ADD: 1+2+4 = 7.0
    ops[0] = 32'h3F80_0000; ops[1] = 32'h4000_0000;
    n_ops = 2; restart_at = 5; spur_en = 1'b1;
    launch(8'd2, 32'h3F80_0000);
    run_until_done("dist", 400);
    restart_at = -1; spur_en = 1'b0;
    check_eq("dist_result", result, 32'h40E0_0000);
    check_eq("dist_cs", 32'(mon_cs), 32'd2);
    check_eq("dist_ae", 32'(mon_ae), 32'd2);
    check_eq("dist_done_cnt", 32'(mon_done), 32'd1);
    check_eq("dist_idle", 32'(busy), 32'd0);

    // Reset during ADD of a len=4 job, then a fresh len=1 job.
    ops[0] = 32'h3F80_0000; ops[1] = 32'h4000_0000;
    ops[2] = 32'h4040_0000; ops[3] = 32'h4080_0000;
    n_ops = 4;
    launch(8'd4, 32'h0);
    while (mon_ae < 2 && mon_cycles < 300) step();
    check_eq("rst_mid_reached_add", 32'(mon_ae), 32'd2);
    n_ops = 0; in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_result", result, 32'h0);
    clear_mon();
    repeat (30) step();
    check_eq("rst_mid_no_done", 32'(mon_done), 32'd0);

    ops[0] = 32'h40A0_0000;
    n_ops = 1;
    launch(8'd1, 32'h3F80_0000);
    run_until_done("after_rst", 300);
    check_eq("after_rst_result", result, 32'h4130_0000);
    check_eq("after_rst_done_cnt", 32'(mon_done), 32'd1);

    // Silent CORDIC with TIMEOUT=15.
    @(negedge clk);
    start_t = 1'b1; len_t = 8'd1; init_t = 32'h0;
    in_valid_t = 1'b1; in_data_t = 32'h3F80_0000;
    @(negedge clk);
    start_t = 1'b0;
    n = 0;
    while (!cordic_start_t && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid_t = 1'b0;
    check_eq("to_cordic_start", 32'(cordic_start_t), 32'd1);
    n = 0; dt = 0;
    while (!error_t && n < 100) begin
      @(negedge clk);
      n++;
      if (done_t) dt++;
    end
    check_eq("to_wait_cycles", 32'(n), 32'd15);
    repeat (10) begin
      @(negedge clk);
      if (done_t) dt++;
    end
    check_eq("to_error_hold", 32'(error_t), 32'd1);
    check_eq("to_busy_hold", 32'(busy_t), 32'd1);
    check_eq("to_no_done", 32'(dt), 32'd0);
    check_eq("to_result", result_t, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("to_rst_error", 32'(error_t), 32'd0);
    check_eq("to_rst_busy", 32'(busy_t), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_cordic_sum_sequencer
`default_nettype wire

// File: doc/cordic_sum_sequencer.md
CORDIC_SUM_SEQUENCER -- requirements
Module: cordic_sum_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the operand-count input.
REQ-002 SHALL have parameter TIMEOUT, default 1023: maximum cycles to wait for any sub-unit done.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle job request, sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_W: number of operands in the job, latched on start.
REQ-007 SHALL have port init_sum, input, 32: IEEE-754 single starting sum, latched on start.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 32): operand stream, transferred when both valid and ready are high.
REQ-009 SHALL have ports cordic_start (output, 1), cordic_data (output, 32), cordic_done (input, 1) and cordic_result (input, 32): shared CORDIC unit.
REQ-010 SHALL have ports add_enable (output, 1), add_dataa (output, 32), add_datab (output, 32), add_done (input, 1) and add_result (input, 32): shared FP adder.
REQ-011 SHALL have ports result (output, 32), done (output, 1), busy (output, 1) and error (output, 1).

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, CORDIC, ADD, FINISH and FAULT.
REQ-013 IDLE: a start pulse SHALL latch len, init_sum into acc and remcnt, then go to FETCH; or go to FINISH if len==0.
REQ-014 FETCH SHALL drive in_ready=1; on transfer, latch in_data into cordic_data, pulse cordic_start for exactly 1 cycle, then go to CORDIC.
REQ-015 CORDIC: on cordic_done, latch cordic_result into add_dataa, drive add_datab=acc, pulse add_enable for 1 cycle, then go to ADD.
REQ-016 ADD: on add_done, acc<=add_result and remcnt<=remcnt-1; go to FINISH if remcnt was 1, else to FETCH.
REQ-017 FINISH SHALL register result<=acc, pulse done for 1 cycle and return to IDLE.
REQ-018 Minimum per-operand overhead SHALL be 3 controller cycles plus the sub-unit latencies; FINISH SHALL add 1 cycle.
REQ-019 in_ready SHALL be high only in FETCH; operands offered in other states SHALL NOT be consumed.
REQ-020 cordic_start and add_enable SHALL never be high in the same cycle, and never more than once per operand.
REQ-021 cordic_done outside CORDIC and add_done outside ADD SHALL be ignored.
REQ-022 start while busy SHALL be ignored; busy SHALL be high in every state except IDLE.
REQ-023 A wait counter SHALL reset on entry to CORDIC/ADD; on reaching TIMEOUT the FSM SHALL go to FAULT.
REQ-024 FAULT SHALL hold error=1 and busy=1, leaving result unchanged, until reset.
REQ-025 len SHALL be treated as unsigned; len=2^LEN_W-1 SHALL be fully processed without counter wrap.
REQ-026 The block SHALL do no floating-point arithmetic itself; sums come only from add_result.

Reset
REQ-027 With rst_n low at a clock edge: state=IDLE; result=0; acc=0; remcnt=0; done=busy=error=in_ready=cordic_start=add_enable=0; cordic_data, add_dataa and add_datab=0.
REQ-028 Reset mid-job SHALL abandon the job with no done pulse; a late sub-unit done after reset SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the default TIMEOUT, and the FP constants FP_ZERO=32'h00000000 and FP_ONE=32'h3F800000.
REQ-030 The wait-timeout counter SHALL be a single sub-module, seq_watchdog (ports clk, rst_n, clear, expired).
REQ-031 The CORDIC and adder SHALL be instantiated outside this block and connected at the parent level.

Verification
REQ-032 Bench models: CORDIC returning f(x) after 20 cycles, adder returning the exact FP sum after 6 cycles.
REQ-033 start, len=0, init_sum=32'h40490FDB -> done 1 cycle after FINISH entry, result=32'h40490FDB, no cordic_start.
REQ-034 len=3, init_sum=0, in_data 3F800000/40000000/40400000 (in_valid gapped) -> exactly 3 cordic_start and 3 add_enable pulses, result=f(1)+f(2)+f(3).
REQ-035 start pulsed again mid-job and a spurious cordic_done during ADD -> both ignored; the job result is unchanged.
REQ-036 CORDIC model never asserts done, TIMEOUT=15 -> FAULT with error=1 after 15 wait cycles; done never pulses; rst_n low clears error.
REQ-037 rst_n low during ADD of a len=4 job, then a new len=1 job -> no done for the old job, correct result for the new job.
